// File: rtl/tetris_pkg.sv
// Shared constants for the Tetris display path: VGA 640x480@60 timing,
// RGB332 palette and the colour-code field width.
package tetris_pkg;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;
   localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int unsigned HV_W    = 10;
   localparam int unsigned COLOR_W = 3;

   // Ascending index range so PALETTE[0] is the leftmost entry.
   localparam logic [0:7][7:0] PALETTE = {8'h00, 8'h1F, 8'hFC, 8'hA3,
                                          8'h1C, 8'hE0, 8'h03, 8'hF0};

endpackage

// File: rtl/grid_renderer_if.sv
// Grid memory read port B: renderer drives the address, memory returns data
// one clock later.
interface grid_renderer_if;
   logic [7:0] grid_addr_b;
   logic [7:0] grid_q_b;

   modport master (output grid_addr_b, input grid_q_b);
   modport slave  (input grid_addr_b, output grid_q_b);
endinterface

// File: rtl/grid_renderer_vga_timing.sv
// Pixel-tick divider and 800x525 h/v counters with raw sync/blank and the
// frame_start pulse issued when the counters wrap to (0,0).
module vga_timing
   import tetris_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            tick,
   output logic [HV_W-1:0] h,
   output logic [HV_W-1:0] v,
   output logic            hsync_raw,
   output logic            vsync_raw,
   output logic            blank_raw,
   output logic            frame_start
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [HV_W-1:0]  H_LAST   = HV_W'(H_TOTAL - 1);
   localparam logic [HV_W-1:0]  V_LAST   = HV_W'(V_TOTAL - 1);
   localparam logic [HV_W-1:0]  HS_LO    = HV_W'(H_VISIBLE + H_FRONT);
   localparam logic [HV_W-1:0]  HS_HI    = HV_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [HV_W-1:0]  VS_LO    = HV_W'(V_VISIBLE + V_FRONT);
   localparam logic [HV_W-1:0]  VS_HI    = HV_W'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] div;

   assign tick = (div == DIV_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div         <= '0;
         h           <= '0;
         v           <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (tick) begin
            div <= '0;
            if (h == H_LAST) begin
               h <= '0;
               if (v == V_LAST) begin
                  v           <= '0;
                  frame_start <= 1'b1;
               end else begin
                  v <= v + 10'd1;
               end
            end else begin
               h <= h + 10'd1;
            end
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   assign hsync_raw = !((h >= HS_LO) && (h < HS_HI));
   assign vsync_raw = !((v >= VS_LO) && (v < VS_HI));
   assign blank_raw = (h >= HV_W'(H_VISIBLE)) || (v >= HV_W'(V_VISIBLE));

endmodule

// File: rtl/grid_renderer.sv
// Raster-order reader of Grid_Mem port B producing RGB332 VGA pixels.
// Optional white playfield border: define GRID_RENDER_BORDER_EN.
module grid_renderer
   import tetris_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned GRID_COLS   = 10,
   parameter int unsigned GRID_ROWS   = 24,
   parameter int unsigned HIDDEN_ROWS = 4,
   parameter int unsigned CELL_PX     = 16,
   parameter int unsigned X0          = 240,
   parameter int unsigned Y0          = 80,
   parameter logic [7:0]  BG_COLOR    = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   grid_renderer_if.master  grid,
   output logic             hsync,
   output logic             vsync,
   output logic             blank,
   output logic [7:0]       rgb,
   output logic             frame_start
);

   localparam logic [HV_W-1:0] X_LO      = HV_W'(X0);
   localparam logic [HV_W-1:0] X_HI      = HV_W'(X0 + GRID_COLS * CELL_PX);
   localparam logic [HV_W-1:0] Y_LO      = HV_W'(Y0);
   localparam logic [HV_W-1:0] Y_HI      = HV_W'(Y0 + (GRID_ROWS - HIDDEN_ROWS) * CELL_PX);
   localparam logic [HV_W-1:0] CELL_MASK = HV_W'(CELL_PX - 1);
   localparam logic [HV_W-1:0] H_LAST    = HV_W'(H_TOTAL - 1);
   localparam logic [HV_W-1:0] V_LAST    = HV_W'(V_TOTAL - 1);
   localparam logic [7:0]      ROW_BASE0 = 8'(HIDDEN_ROWS * GRID_COLS);
   localparam logic [7:0]      ROW_STEP  = 8'(GRID_COLS);

   logic            tick;
   logic [HV_W-1:0] h, v, h_off, v_off, v_next;
   logic            hs_raw, vs_raw, bl_raw;
   logic            in_h, in_v, in_win, line_end;
   logic [7:0]      col, row_base, addr_next, pix;
   logic            hs1, vs1, bl1, win1;

   vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .h           (h),
      .v           (v),
      .hsync_raw   (hs_raw),
      .vsync_raw   (vs_raw),
      .blank_raw   (bl_raw),
      .frame_start (frame_start)
   );

   assign in_h      = (h >= X_LO) && (h < X_HI);
   assign in_v      = (v >= Y_LO) && (v < Y_HI);
   assign in_win    = in_h && in_v;
   assign h_off     = h - X_LO;
   assign v_off     = v - Y_LO;
   assign line_end  = (h == H_LAST);
   assign v_next    = (v == V_LAST) ? '0 : v + 10'd1;
   assign addr_next = in_win ? row_base + col : '0;

   // Row base is prepared for the next line at each line end, so the
   // address is available without a multiplier on the current line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col      <= '0;
         row_base <= '0;
      end else if (tick) begin
         if (!in_win)
            col <= '0;
         else if ((h_off & CELL_MASK) == CELL_MASK)
            col <= col + 8'd1;
         if (line_end) begin
            if (v_next == Y_LO)
               row_base <= ROW_BASE0;
            else if (in_v && ((v_off & CELL_MASK) == CELL_MASK))
               row_base <= row_base + ROW_STEP;
         end
      end
   end

`ifdef GRID_RENDER_BORDER_EN
   localparam logic [HV_W-1:0] BX_LO = HV_W'(X0 - 2);
   localparam logic [HV_W-1:0] BX_HI = HV_W'(X0 + GRID_COLS * CELL_PX + 2);
   localparam logic [HV_W-1:0] BY_LO = HV_W'(Y0 - 2);
   localparam logic [HV_W-1:0] BY_HI = HV_W'(Y0 + (GRID_ROWS - HIDDEN_ROWS) * CELL_PX + 2);

   logic bord, bord1;

   assign bord = (h >= BX_LO) && (h < BX_HI) && (v >= BY_LO) && (v < BY_HI);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         bord1 <= 1'b0;
      else if (tick)
         bord1 <= bord;
   end
`endif

   always_comb begin
      pix = BG_COLOR;
      if (bl1)
         pix = '0;
      else if (win1)
         pix = PALETTE[grid.grid_q_b[COLOR_W-1:0]];
`ifdef GRID_RENDER_BORDER_EN
      else if (bord1)
         pix = 8'hFF;
`endif
   end

   // Stage 1 (address + sideband) and stage 2 (outputs) both advance on the
   // pixel tick; memory data arrives in between.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grid.grid_addr_b <= '0;
         hs1              <= 1'b1;
         vs1              <= 1'b1;
         bl1              <= 1'b1;
         win1             <= 1'b0;
         hsync            <= 1'b1;
         vsync            <= 1'b1;
         blank            <= 1'b1;
         rgb              <= '0;
      end else if (tick) begin
         grid.grid_addr_b <= addr_next;
         hs1              <= hs_raw;
         vs1              <= vs_raw;
         bl1              <= bl_raw;
         win1             <= in_win;
         hsync            <= hs1;
         vsync            <= vs1;
         blank            <= bl1;
         rgb              <= pix;
      end
   end

endmodule

// File: doc/grid_renderer.md
# grid_renderer

Read-side consumer of the Tetris grid memory. Runs 640x480@60 VGA timing from the system clock, walks the visible playfield in raster order on Grid_Mem port B (synchronous, 1-cycle read latency) and converts each cell's colour code to RGB332 pixels with aligned sync and blank. It sits between Grid_Mem port B and the VGA pins. Grid_Controller owns port A; this block never writes memory.

## Interface
- CLK_DIV, 2: system clocks per pixel; 50 MHz / 2 = 25 MHz pixel rate.
- GRID_COLS, 10: cells per memory row.
- GRID_ROWS, 24: memory rows. Rows 0..HIDDEN_ROWS-1 are the spawn area.
- HIDDEN_ROWS, 4: memory rows not displayed.
- CELL_PX, 16: pixels per cell edge, power of two.
- X0, 240: playfield left pixel column.
- Y0, 80: playfield top pixel line.
- BG_COLOR, 8'h00: RGB332 colour outside the playfield during active video.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- grid_addr_b  out  8  port B address.
- grid_q_b  in  8  port B data, valid one clk after the address. Bits [2:0] are the colour code (0 = empty); bits [7:3] are ignored.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- blank  out  1  high outside the 640x480 active area.
- rgb  out  8  RGB332 pixel, forced to 0 while blank.
- frame_start  out  1  one-clk pulse on the pixel tick where the counters wrap to (0,0).

## Operation
- Pixel tick: a divider counts 0..CLK_DIV-1 and the tick fires on the last count. The h and v counters advance only on a tick.
- Horizontal line: 800 pixels total, 640 visible. Front porch 16, sync 96 (h = 656..751), back porch 48.
- Vertical frame: 525 lines total, 480 visible. Front porch 10, sync 2 (v = 490..491), back porch 33.
- h wraps 799->0. On that wrap v increments, and v wraps 524->0.
- Playfield window: X0 <= h < X0+GRID_COLS*CELL_PX and Y0 <= v < Y0+(GRID_ROWS-HIDDEN_ROWS)*CELL_PX.
- Cell address: (vis_row+HIDDEN_ROWS)*GRID_COLS + col. No multiplier is used.
  - A row-base register loads HIDDEN_ROWS*GRID_COLS at v = Y0.
  - It adds GRID_COLS each time v crosses a cell boundary inside the window.
  - A column counter increments every CELL_PX pixels inside the window.
- Outside the window grid_addr_b = 0.
- Colour path: a cell with code c displays PALETTE[c]. Code 0 displays PALETTE[0] = 8'h00. Outside the window the pixel is BG_COLOR.

## Timing
- Address stage: grid_addr_b is registered on the tick where the counters hold (h,v).
- Data stage: grid_q_b is sampled on the next clk and converted through the palette.
- Output alignment: rgb, blank, hsync and vsync for pixel (h,v) are registered together exactly 2 pixel ticks after the counters held (h,v). Sync and blank are delayed through the same 2-tick pipeline, so no output is ever misaligned.
- CLK_DIV must be >= 2 so the 1-cycle memory latency fits within one pixel period. With CLK_DIV = 1 the behaviour is undefined.
- Reset values (asserted asynchronously):
  - divider, h, v, column counter, row base: 0;
  - pipeline contents cleared;
  - grid_addr_b = 0, hsync = 1, vsync = 1, blank = 1, rgb = 0, frame_start = 0.
- Reset mid-frame: all outputs return to reset values immediately. After release, the first frame starts at (0,0) with no partial-frame pulse.
- Memory writes by Grid_Controller mid-frame take effect from the next read of that address. No frame buffering.

## Configuration
- GRID_RENDER_BORDER_EN defined: pixels within 2 pixels outside the playfield window show 8'hFF (white border). This overrides BG_COLOR.
- GRID_RENDER_BORDER_EN undefined: those pixels show BG_COLOR. No border logic is present.

## Structure
- tetris_pkg holds:
  - the VGA timing constants (visible, porch and sync widths, totals);
  - the 8-entry RGB332 PALETTE: 00, 1F, FC, A3, 1C, E0, 03, F0;
  - the colour-code field width.
- Sub-module vga_timing: pixel-tick divider, h/v counters, raw hsync/vsync/blank and frame_start. The cell addressing and colour pipeline stay in grid_renderer.

## Test plan
- Reset low for 3 clks -> hsync = 1, vsync = 1, blank = 1, rgb = 0, grid_addr_b = 0. After release, hsync first falls at h = 656 (observed 2 ticks later), i.e. 1312+4 clks after release with CLK_DIV = 2.
- Memory all 0 -> every playfield pixel rgb = 00. One frame is exactly 800*525*2 = 840000 clks between frame_start pulses.
- Write 8'h01 at address 65 -> rgb = 8'h1F for h 320..335, v 112..127. rgb = 00 for all other playfield pixels.
- Write 8'h05 at address 0 (hidden row) -> no E0 pixel appears anywhere. Write 8'h05 at address 40 -> E0 at h 240..255, v 80..95.
- Assert reset at v = 300 for 1 clk -> outputs take reset values within the same clk. The next frame_start comes 840000 clks after release.
- GRID_RENDER_BORDER_EN defined -> rgb = FF at (238,200) and (400,200); rgb = 00 at (237,200).
